writeback_mem_control: RTL and testbench
========================================

# writeback_mem_control

Write-side address generator for the systolic array's output memory. It is the counterpart of the read-side master memory controller: it captures the skewed result wavefront leaving the array and emits per-lane write enables and write addresses, so that row r of the result tile lands at `base_addr + r` in every active column lane. Each job is started by a one-cycle `active` pulse from the top-level controller. The block reports completion with a one-cycle `done` pulse.

## Interface
- `addr_width`, 8: width of one lane address.
- `width_height`, 16: array dimension and number of write lanes.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `active` input 1: start pulse, sampled only in IDLE.
- `base_addr` input `addr_width`: first row address of the result tile.
- `num_row` input `$clog2(width_height)+1`: result rows to write.
- `num_col` input `$clog2(width_height)+1`: result columns (lanes) to write.
- `wait_cycles` input 8: array pipeline latency between `active` and the first result on lane 0.
- `out_addr` output `addr_width*width_height`: lane j address in bits `[j*addr_width +: addr_width]`.
- `wr_en` output `width_height`: per-lane write enable, bit j is lane j.
- `busy` output 1: job in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, WRITE, DONE.
- IDLE with `active`=1: latch `base_addr`, `num_row`, `num_col` and `wait_cycles`, then go to WAIT. `active` in any other state is ignored.
- Clamping: a latched `num_row` or `num_col` greater than `width_height` is clamped to `width_height`.
- WAIT: counts down the latched `wait_cycles`, then goes to WRITE. If either latched dimension is 0, it goes to DONE instead of WRITE.
- WRITE: step counter t runs from 0 to `R+C-2`, where R and C are the latched row and column counts.
  - Lane j is enabled in step t iff `j < C`, `t >= j` and `t-j < R`.
  - The enabled lane's address is `(base_addr + t - j) mod 2^addr_width`, with wrap-around permitted.
  - Disabled lanes drive `wr_en`=0 and address 0.
- DONE: asserts `done` for one cycle, then returns to IDLE.
- Reset: `reset`=0 at any time forces IDLE and drives all outputs to 0. An aborted job produces no `done`.

## Timing
- Reset values: `out_addr`=0, `wr_en`=0, `busy`=0, `done`=0.
- `out_addr`, `wr_en`, `busy` and `done` are all registered. No output has a combinational path from any input.
- Cycle 0 is the edge that samples `active`=1 in IDLE. With W = latched `wait_cycles`:
  - `busy`=1 from cycle 1 through the `done` cycle inclusive.
  - Step t is visible on `wr_en`/`out_addr` in cycle `1+W+t`.
  - `done`=1 in cycle `1+W+R+C-1`.
  - For a zero-size job, `done`=1 in cycle `1+W`.
- `busy`=0 in the cycle after `done`. A new `active` is accepted from that cycle.
- Input changes while `busy`=1 have no effect on the running job.

## Structure
- The shared package holds:
  - the state enum (IDLE, WAIT, WRITE, DONE);
  - localparams for the step-counter width (`$clog2(2*width_height)`) and the dimension width (`$clog2(width_height)+1`).
- The sub-module `writeback_lane` is instantiated `width_height` times through a generate loop.
  - Inputs: lane index j (parameter), t, R, C, base, and the WRITE-state flag.
  - Outputs: the next-state `wr_en` bit and the lane address.
- The top level holds the FSM, the wait counter, the step counter and the output registers.

## Test plan
- Full tile: `base_addr`=0x10, R=C=16, W=3, `active` at cycle 0.
  - Cycle 4: lane 0 only, address 0x10.
  - Cycle 19: lane 15 first write, address 0x10.
  - `done` at cycle 35.
  - Each lane writes exactly 16 consecutive addresses 0x10–0x1F.
- Partial tile: R=3, C=2, W=0, base 0.
  - Cycle 1: `wr_en`=0b01.
  - Cycle 2: `wr_en`=0b11, addresses {1,0}.
  - Cycle 3: `wr_en`=0b11, addresses {2,1}.
  - Cycle 4: `wr_en`=0b10, address 2.
  - `done` at cycle 5.
  - Lanes 2–15 never asserted.
- Address wrap: `base_addr`=0xFE, R=4, C=1 → lane 0 writes 0xFE, 0xFF, 0x00, 0x01.
- Zero and oversize dimensions:
  - R=0, W=2 → no `wr_en` ever, `done` at cycle 3.
  - R=20, C=1 is clamped → exactly 16 writes.
- Busy behaviour: `active` re-pulsed mid-WRITE and on the `done` cycle → ignored. A pulse one cycle after `done` starts a new job.
- Asynchronous reset mid-WRITE (asserted between edges): all outputs 0 immediately, no `done`. After release, a fresh job runs to completion correctly.

Source files
------------

// File: rtl/writeback_mem_control_pkg.sv
// Shared types and default widths for the output-memory write-side address generator.
package writeback_mem_control_pkg;

  localparam int WB_ADDR_W = 8;
  localparam int WB_WH     = 16;
  localparam int WB_STEP_W = $clog2(2 * WB_WH);
  localparam int WB_DIM_W  = $clog2(WB_WH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/writeback_mem_control_lane.sv
// One write lane: decides whether lane lane_idx writes in step t and which row address it targets.
module writeback_lane #(
  parameter int lane_idx   = 0,
  parameter int addr_width = 8,
  parameter int step_w     = 5,
  parameter int dim_w      = 5
) (
  input  logic [step_w-1:0]     t_i,
  input  logic [dim_w-1:0]      rows_i,
  input  logic [dim_w-1:0]      cols_i,
  input  logic [addr_width-1:0] base_i,
  input  logic                  write_i,
  output logic                  wr_en_o,
  output logic [addr_width-1:0] addr_o
);

  localparam int CW = step_w + 1;

  logic [CW-1:0] t_ext;
  logic [CW-1:0] lane_ext;
  logic [CW-1:0] row_idx;

  // row_idx = t - j is the result row reaching this lane in step t (skewed wavefront).
  always_comb begin
    t_ext    = CW'(t_i);
    lane_ext = CW'(lane_idx);
    row_idx  = t_ext - lane_ext;
    wr_en_o  = write_i
               && (CW'(cols_i) > lane_ext)
               && (t_ext >= lane_ext)
               && (row_idx < CW'(rows_i));
    addr_o   = '0;
    if (wr_en_o) begin
      addr_o = base_i + addr_width'(row_idx);
    end
  end

endmodule

// File: rtl/writeback_mem_control.sv
// Write-side address generator: turns the skewed result wavefront into per-lane write enables
// and row addresses, one job per start pulse, with a one-cycle completion pulse.
module writeback_mem_control
  import writeback_mem_control_pkg::*;
#(
  parameter int addr_width   = WB_ADDR_W,
  parameter int width_height = WB_WH,
  localparam int DIM_W  = $clog2(width_height) + 1,
  localparam int STEP_W = $clog2(2 * width_height)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               active,
  input  logic [addr_width-1:0]              base_addr,
  input  logic [DIM_W-1:0]                   num_row,
  input  logic [DIM_W-1:0]                   num_col,
  input  logic [7:0]                         wait_cycles,
  output logic [addr_width*width_height-1:0] out_addr,
  output logic [width_height-1:0]            wr_en,
  output logic                               busy,
  output logic                               done
);

  localparam int SW1 = STEP_W + 1;
  localparam logic [DIM_W-1:0] WH_DIM = DIM_W'(width_height);

  wb_state_e                          state_q, state_d;
  logic [7:0]                         wait_q, wait_d;
  logic [STEP_W-1:0]                  t_q, t_d;
  logic [addr_width-1:0]              base_q, base_d;
  logic [DIM_W-1:0]                   rows_q, rows_d;
  logic [DIM_W-1:0]                   cols_q, cols_d;
  logic [width_height-1:0]            wr_en_q;
  logic [addr_width*width_height-1:0] addr_q;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;

  logic                               emit;
  logic [STEP_W-1:0]                  t_emit;
  logic                               zero_dim;
  logic [SW1-1:0]                     span;
  logic [STEP_W-1:0]                  last_step;
  logic [width_height-1:0]            lane_en;
  logic [addr_width*width_height-1:0] lane_addr;

  assign zero_dim  = (rows_q == '0) || (cols_q == '0);
  assign span      = SW1'(rows_q) + SW1'(cols_q);
  assign last_step = STEP_W'(span - SW1'(2));

  // Handshake: active is a start pulse honoured only in IDLE; busy covers cycle 1 through the
  // done cycle, done pulses once per finished job, and active is accepted again once busy drops.
  // Step 0 is emitted from WAIT on its final cycle so it lands exactly W+1 cycles after start.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    t_d     = t_q;
    base_d  = base_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    emit    = 1'b0;
    t_emit  = t_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active) begin
          base_d  = base_addr;
          rows_d  = (num_row > WH_DIM) ? WH_DIM : num_row;
          cols_d  = (num_col > WH_DIM) ? WH_DIM : num_col;
          wait_d  = wait_cycles;
          t_d     = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q != 8'd0) begin
          wait_d = wait_q - 8'd1;
        end else if (zero_dim) begin
          // Nothing to write: complete in the slot where step 0 would have appeared.
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          emit   = 1'b1;
          t_emit = '0;
          if (last_step == '0) begin
            state_d = ST_DONE;
          end else begin
            t_d     = STEP_W'(1);
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        emit = 1'b1;
        if (t_q == last_step) begin
          state_d = ST_DONE;
        end else begin
          t_d = t_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_q != ST_IDLE);
  end

  for (genvar j = 0; j < width_height; j++) begin : g_lane
    writeback_lane #(
      .lane_idx  (j),
      .addr_width(addr_width),
      .step_w    (STEP_W),
      .dim_w     (DIM_W)
    ) u_lane (
      .t_i    (t_emit),
      .rows_i (rows_q),
      .cols_i (cols_q),
      .base_i (base_q),
      .write_i(emit),
      .wr_en_o(lane_en[j]),
      .addr_o (lane_addr[j*addr_width +: addr_width])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      t_q     <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      wr_en_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      t_q     <= t_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      wr_en_q <= lane_en;
      addr_q  <= lane_addr;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_addr = addr_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_writeback_mem_control.sv
// Scoreboard bench for writeback_mem_control: jobs push per-cycle expected records, a negedge
// monitor pops one record for every cycle the DUT shows busy, done or any write enable.
module tb_writeback_mem_control;

  localparam int AW = 8;
  localparam int WH = 16;
  localparam int DW = 5;
  localparam int RW = 16 + 2 + WH + AW * WH;
  localparam int NO_STOP = 32'h7fff_ffff;

  logic            clk = 1'b0;
  logic            reset;
  logic            active;
  logic [AW-1:0]   base_addr;
  logic [DW-1:0]   num_row;
  logic [DW-1:0]   num_col;
  logic [7:0]      wait_cycles;
  logic [AW*WH-1:0] out_addr;
  logic [WH-1:0]   wr_en;
  logic            busy;
  logic            done;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  logic [RW-1:0] exp_q[$];

  int         lane_cnt[WH];
  logic [7:0] lane_first[WH];
  logic [7:0] lane_prev[WH];
  logic       lane_bad[WH];

  writeback_mem_control #(
    .addr_width  (AW),
    .width_height(WH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .base_addr  (base_addr),
    .num_row    (num_row),
    .num_col    (num_col),
    .wait_cycles(wait_cycles),
    .out_addr   (out_addr),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [RW-1:0] obs;
    if (reset === 1'b1 && (busy || done || wr_en != '0)) begin
      obs = {16'(cyc), busy, done, wr_en, out_addr};
      for (int j = 0; j < WH; j++) begin
        if (wr_en[j]) begin
          if (lane_cnt[j] == 0) lane_first[j] = out_addr[j*AW +: AW];
          else if (out_addr[j*AW +: AW] != lane_prev[j] + 8'd1) lane_bad[j] = 1'b1;
          lane_prev[j] = out_addr[j*AW +: AW];
          lane_cnt[j]++;
        end
      end
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none", obs);
      end else begin
        check("scoreboard", obs, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b, input logic [DW-1:0] r, input logic [DW-1:0] c,
                       input logic [7:0] w, output int s);
    base_addr   = b;
    num_row     = r;
    num_col     = c;
    wait_cycles = w;
    active      = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    active = 1'b0;
  endtask

  task automatic push_rec(input int k, input logic dn, input logic [WH-1:0] en,
                          input logic [AW*WH-1:0] ad);
    exp_q.push_back({16'(k), 1'b1, dn, en, ad});
  endtask

  task automatic push_model(input int base, input int r_in, input int c_in, input int w,
                            input int s, input int stop);
    int rr, cc, first, done_c, t;
    logic [WH-1:0]    en;
    logic [AW*WH-1:0] ad;
    rr = (r_in > WH) ? WH : r_in;
    cc = (c_in > WH) ? WH : c_in;
    first  = s + 1 + w;
    done_c = (rr == 0 || cc == 0) ? first : first + rr + cc - 1;
    for (int k = s + 1; k <= done_c && k <= stop; k++) begin
      en = '0;
      ad = '0;
      t  = k - first;
      if (rr > 0 && cc > 0 && t >= 0) begin
        for (int j = 0; j < cc; j++) begin
          if (t >= j && t - j < rr) begin
            en[j] = 1'b1;
            ad[j*AW +: AW] = AW'(base + t - j);
          end
        end
      end
      exp_q.push_back({16'(k), 1'b1, (k == done_c), en, ad});
    end
  endtask

  task automatic clear_tally();
    for (int j = 0; j < WH; j++) begin
      lane_cnt[j]   = 0;
      lane_first[j] = '0;
      lane_prev[j]  = '0;
      lane_bad[j]   = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int done_c);
    wait_until(done_c + 2);
    check(name, RW'(exp_q.size()), '0);
  endtask

  initial begin : stimulus
    int s, sb;
    reset = 1'b1; active = 1'b0; base_addr = '0; num_row = '0; num_col = '0; wait_cycles = '0;
    clear_tally();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_values", RW'({out_addr, wr_en, busy, done}), '0);
    reset = 1'b1;
    @(negedge clk);

    // full 16x16 tile, base 0x10, W=3: done at +35
    clear_tally();
    pulse(8'h10, 5'd16, 5'd16, 8'd3, s);
    push_model(8'h10, 16, 16, 3, s, NO_STOP);
    drain("full_tile_drain", s + 35);
    for (int j = 0; j < WH; j++)
      check($sformatf("full_lane%0d_span", j),
            RW'({lane_cnt[j], lane_first[j], lane_bad[j]}), RW'({32'd16, 8'h10, 1'b0}));

    // partial tile R=3 C=2 W=0 base 0, hand-computed
    pulse(8'h00, 5'd3, 5'd2, 8'd0, s);
    push_rec(s + 1, 1'b0, 16'h0001, 128'h0000);
    push_rec(s + 2, 1'b0, 16'h0003, 128'h0001);
    push_rec(s + 3, 1'b0, 16'h0003, 128'h0102);
    push_rec(s + 4, 1'b0, 16'h0002, 128'h0200);
    push_rec(s + 5, 1'b1, 16'h0000, 128'h0000);
    drain("partial_drain", s + 5);

    // address wrap base 0xFE, R=4 C=1 W=1
    pulse(8'hFE, 5'd4, 5'd1, 8'd1, s);
    push_rec(s + 1, 1'b0, 16'h0000, 128'h00);
    push_rec(s + 2, 1'b0, 16'h0001, 128'hFE);
    push_rec(s + 3, 1'b0, 16'h0001, 128'hFF);
    push_rec(s + 4, 1'b0, 16'h0001, 128'h00);
    push_rec(s + 5, 1'b0, 16'h0001, 128'h01);
    push_rec(s + 6, 1'b1, 16'h0000, 128'h00);
    drain("wrap_drain", s + 6);

    // zero rows, W=2: done at +3, no writes
    pulse(8'h20, 5'd0, 5'd4, 8'd2, s);
    push_rec(s + 1, 1'b0, 16'h0000, 128'h0);
    push_rec(s + 2, 1'b0, 16'h0000, 128'h0);
    push_rec(s + 3, 1'b1, 16'h0000, 128'h0);
    drain("zero_row_drain", s + 3);

    // zero columns, W=0: done at +1
    pulse(8'h20, 5'd5, 5'd0, 8'd0, s);
    push_rec(s + 1, 1'b1, 16'h0000, 128'h0);
    drain("zero_col_drain", s + 1);

    // oversize rows clamp to 16
    clear_tally();
    pulse(8'h30, 5'd20, 5'd1, 8'd0, s);
    push_model(8'h30, 20, 1, 0, s, NO_STOP);
    drain("oversize_drain", s + 17);
    check("oversize_lane0", RW'({lane_cnt[0], lane_first[0], lane_bad[0]}),
          RW'({32'd16, 8'h30, 1'b0}));
    check("oversize_lane1", RW'(lane_cnt[1]), '0);

    // busy: re-pulses mid-WRITE and on the done edge ignored, next edge accepted
    pulse(8'h40, 5'd2, 5'd3, 8'd1, s);
    push_model(8'h40, 2, 3, 1, s, NO_STOP);
    wait_until(s + 2);
    pulse(8'hAA, 5'd16, 5'd16, 8'd0, sb);
    wait_until(s + 5);
    pulse(8'hAA, 5'd16, 5'd16, 8'd0, sb);
    pulse(8'h50, 5'd1, 5'd1, 8'd0, sb);
    check("restart_cycle", RW'(sb), RW'(s + 7));
    push_model(8'h50, 1, 1, 0, sb, NO_STOP);
    drain("busy_drain", sb + 2);

    // asynchronous reset mid-WRITE
    pulse(8'h80, 5'd16, 5'd16, 8'd2, s);
    push_model(8'h80, 16, 16, 2, s, s + 10);
    wait_until(s + 10);
    #2 reset = 1'b0;
    #1 check("abort_outputs", RW'({out_addr, wr_en, busy, done}), '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("abort_flush", RW'(exp_q.size()), '0);
    repeat (3) @(negedge clk);

    // fresh job after reset
    pulse(8'h00, 5'd4, 5'd4, 8'd1, s);
    push_model(8'h00, 4, 4, 1, s, NO_STOP);
    drain("fresh_drain", s + 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
